// File: rtl/control_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE sequencer driving ALU control and register/PC/memory strobes.
// Define MEM_HANDSHAKE_EN to make memory states wait for mem_ack; otherwise each memory state lasts one cycle.
module control_sequencer #(
  parameter int unsigned     OPW     = 8,
  parameter logic [OPW-1:0]  HALT_OP = 8'hFF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [OPW-1:0] opcode,
  input  logic           z,
  input  logic           mem_ack,
  output logic [2:0]     alu_op,
  output logic           z_clear,
  output logic           ac_load,
  output logic           ir_load,
  output logic           ar_load,
  output logic           pc_inc,
  output logic           pc_load,
  output logic           addr_sel,
  output logic           mem_rd,
  output logic           mem_wr,
  output logic           halted,
  output logic           illegal_op
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    EXEC    = 4'd2,
    OPERAND = 4'd3,
    JUMP    = 4'd4,
    MEMRD   = 4'd5,
    MEMWR   = 4'd6,
    HALT    = 4'd7
  } state_t;

  localparam logic [OPW-1:0] OP_NOP   = OPW'(0);
  localparam logic [OPW-1:0] OP_ALULO = OPW'(1);
  localparam logic [OPW-1:0] OP_ALUHI = OPW'(6);
  localparam logic [OPW-1:0] OP_JMPZ  = OPW'(7);
  localparam logic [OPW-1:0] OP_JMPNZ = OPW'(8);
  localparam logic [OPW-1:0] OP_LDAC  = OPW'(9);
  localparam logic [OPW-1:0] OP_STAC  = OPW'(10);

  state_t state, nextState;
  logic   ack;

`ifdef MEM_HANDSHAKE_EN
  assign ack = mem_ack;
`else
  logic unusedAck;
  assign unusedAck = mem_ack;
  assign ack       = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= nextState;
  end

  always_comb begin
    nextState  = state;
    alu_op     = 3'd0;
    z_clear    = 1'b0;
    ac_load    = 1'b0;
    ir_load    = 1'b0;
    ar_load    = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    addr_sel   = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    halted     = 1'b0;
    illegal_op = 1'b0;

    case (state)
      FETCH: begin
        mem_rd = 1'b1;
        if (ack) begin
          ir_load   = 1'b1;
          pc_inc    = 1'b1;
          nextState = DECODE;
        end
      end
      DECODE: begin
        // HALT_OP is checked first so a reconfigured halt code wins over any overlap
        if (opcode == HALT_OP)                              nextState = HALT;
        else if (opcode == OP_NOP)                          nextState = FETCH;
        else if (opcode >= OP_ALULO && opcode <= OP_ALUHI)  nextState = EXEC;
        else if (opcode >= OP_JMPZ && opcode <= OP_STAC)    nextState = OPERAND;
        else begin
          illegal_op = 1'b1;
          nextState  = FETCH;
        end
      end
      EXEC: begin
        alu_op    = opcode[2:0];
        ac_load   = 1'b1;
        nextState = FETCH;
      end
      OPERAND: begin
        mem_rd = 1'b1;
        if (ack) begin
          ar_load = 1'b1;
          pc_inc  = 1'b1;
          if (opcode == OP_JMPZ || opcode == OP_JMPNZ) nextState = JUMP;
          else if (opcode == OP_LDAC)                  nextState = MEMRD;
          else if (opcode == OP_STAC)                  nextState = MEMWR;
          else                                         nextState = FETCH;
        end
      end
      JUMP: begin
        z_clear   = 1'b1;
        pc_load   = (opcode == OP_JMPZ && z) || (opcode == OP_JMPNZ && !z);
        nextState = FETCH;
      end
      MEMRD: begin
        mem_rd   = 1'b1;
        addr_sel = 1'b1;
        if (ack) begin
          ac_load   = 1'b1;
          nextState = FETCH;
        end
      end
      MEMWR: begin
        mem_wr   = 1'b1;
        addr_sel = 1'b1;
        if (ack) nextState = FETCH;
      end
      HALT:    halted    = 1'b1;
      default: nextState = FETCH;
    endcase

    if (rst) begin
      alu_op     = 3'd0;
      z_clear    = 1'b0;
      ac_load    = 1'b0;
      ir_load    = 1'b0;
      ar_load    = 1'b0;
      pc_inc     = 1'b0;
      pc_load    = 1'b0;
      addr_sel   = 1'b0;
      mem_rd     = 1'b0;
      mem_wr     = 1'b0;
      halted     = 1'b0;
      illegal_op = 1'b0;
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench: per-instruction expected output traces queued by the stimulus and checked every cycle.
module tb_control_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] opcode = 8'h00;
  logic       z = 1'b0;
  logic       mem_ack = 1'b0;
  logic [2:0] alu_op;
  logic       z_clear, ac_load, ir_load, ar_load, pc_inc, pc_load;
  logic       addr_sel, mem_rd, mem_wr, halted, illegal_op;

`ifdef MEM_HANDSHAKE_EN
  localparam bit HS = 1'b1;
`else
  localparam bit HS = 1'b0;
`endif

  // Output vector layout: {alu_op, z_clear, ac_load, ir_load, ar_load, pc_inc, pc_load, addr_sel, mem_rd, mem_wr, halted, illegal_op}
  localparam logic [13:0] ILL = 14'h0001;
  localparam logic [13:0] HLT = 14'h0002;
  localparam logic [13:0] WR  = 14'h0004;
  localparam logic [13:0] RD  = 14'h0008;
  localparam logic [13:0] AS  = 14'h0010;
  localparam logic [13:0] PCL = 14'h0020;
  localparam logic [13:0] PCI = 14'h0040;
  localparam logic [13:0] ARL = 14'h0080;
  localparam logic [13:0] IRL = 14'h0100;
  localparam logic [13:0] ACL = 14'h0200;
  localparam logic [13:0] ZC  = 14'h0400;

  logic [13:0] expQ[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [13:0] act;

  control_sequencer #(.OPW(8), .HALT_OP(8'hFF)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .z(z), .mem_ack(mem_ack),
    .alu_op(alu_op), .z_clear(z_clear), .ac_load(ac_load), .ir_load(ir_load),
    .ar_load(ar_load), .pc_inc(pc_inc), .pc_load(pc_load), .addr_sel(addr_sel),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .halted(halted), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  assign act = {alu_op, z_clear, ac_load, ir_load, ar_load, pc_inc, pc_load,
                addr_sel, mem_rd, mem_wr, halted, illegal_op};

  always @(negedge clk) begin
    logic [13:0] e;
    cyc++;
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL outputs cycle %0d got %h want %h", cyc, act, e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog cycle %0d got no finish want finish", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic step(input logic r, input logic a, input logic [13:0] e);
    @(posedge clk);
    #1;
    rst = r;
    mem_ack = a;
    expQ.push_back(e);
  endtask

  // A memory access: requested waits apply only with the handshake; without it ack is driven low to show it is ignored.
  task automatic memPhase(input int waits, input logic [13:0] req, input logic [13:0] strobe);
    int w;
    w = HS ? waits : 0;
    for (int i = 0; i < w; i++) step(1'b0, 1'b0, req);
    step(1'b0, (!HS && waits > 0) ? 1'b0 : 1'b1, req | strobe);
  endtask

  task automatic pin(input string name, input logic [13:0] want);
    @(negedge clk);
    #1;
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, want);
    end
  endtask

  task automatic runInstr(input logic [7:0] op, input logic zv, input int wf, input int wo, input int wm);
    logic [13:0] aluv;
    logic        take;
    aluv = {op[2:0], 11'd0};
    take = (op == 8'h07 && zv) || (op == 8'h08 && !zv);
    memPhase(wf, RD, IRL | PCI);
    opcode = op;
    z = zv;
    if (op == 8'hFF) begin
      step(1'b0, 1'b1, '0);
      for (int i = 0; i < 10; i++) step(1'b0, i[0], HLT);
    end else if (op == 8'h00) begin
      step(1'b0, 1'b1, '0);
    end else if (op >= 8'h01 && op <= 8'h06) begin
      step(1'b0, 1'b0, '0);
      step(1'b0, 1'b1, aluv | ACL);
    end else if (op >= 8'h07 && op <= 8'h0A) begin
      step(1'b0, 1'b1, '0);
      memPhase(wo, RD, ARL | PCI);
      if (op == 8'h07 || op == 8'h08) step(1'b0, 1'b1, ZC | (take ? PCL : 14'h0));
      else if (op == 8'h09)           memPhase(wm, RD | AS, ACL);
      else                            memPhase(wm, WR | AS, '0);
    end else begin
      step(1'b0, 1'b1, ILL);
    end
  endtask

  initial begin
    step(1'b1, 1'b1, '0);
    step(1'b1, 1'b0, '0);

    runInstr(8'h02, 1'b0, 0, 0, 0);
    pin("exec_sub", 14'h1200);
    runInstr(8'h01, 1'b0, 0, 0, 0);
    runInstr(8'h05, 1'b0, 3, 0, 0);
    runInstr(8'h07, 1'b1, 0, 1, 0);
    pin("jmpz_taken", 14'h0420);
    runInstr(8'h07, 1'b0, 0, 0, 0);
    pin("jmpz_not_taken", 14'h0400);
    runInstr(8'h08, 1'b0, 1, 0, 0);
    runInstr(8'h08, 1'b1, 0, 0, 0);
    runInstr(8'h09, 1'b0, 0, 2, 1);
    runInstr(8'h0A, 1'b0, 0, 0, 2);
    runInstr(8'h06, 1'b1, 0, 0, 0);
    pin("exec_inc", 14'h3200);
    runInstr(8'h03, 1'b0, 0, 0, 0);
    runInstr(8'h04, 1'b0, 0, 0, 0);
    runInstr(8'h00, 1'b0, 0, 0, 0);
    runInstr(8'h3C, 1'b0, 0, 0, 0);
    pin("illegal_pulse", 14'h0001);
    runInstr(8'h0B, 1'b0, 0, 0, 0);

    // Reset lands in the MEMRD cycle of an LDAC: outputs forced low, no ac_load, FETCH follows.
    memPhase(0, RD, IRL | PCI);
    opcode = 8'h09;
    step(1'b0, 1'b1, '0);
    memPhase(0, RD, ARL | PCI);
    if (HS) step(1'b0, 1'b0, RD | AS);
    step(1'b1, 1'b1, '0);
    pin("rst_in_memrd", 14'h0000);
    runInstr(8'h02, 1'b0, 0, 0, 0);

    runInstr(8'hFF, 1'b0, 0, 0, 0);
    pin("halted", 14'h0002);
    step(1'b1, 1'b0, '0);
    runInstr(8'h01, 1'b0, 0, 0, 0);

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
